// File: rtl/lockin_demod_integrator.sv
// rtl/lockin_demod_integrator.sv - I/Q lock-in demodulator: multiply, settle, integrate 2^N_LOG2 products, dump.
// Define LOCKIN_CONTINUOUS_EN for back-to-back frames (DUMP -> INTEG) instead of single-shot.
module lockin_demod_integrator #(
  parameter int AUDIO_BITS     = 24,
  parameter int LUT_BITS       = 18,
  parameter int N_LOG2         = 10,
  parameter int SETTLE_SAMPLES = 64,
  parameter int OUT_BITS       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic signed [AUDIO_BITS-1:0] audio_in,
  input  logic signed [LUT_BITS-1:0]   cosine_in,
  input  logic signed [LUT_BITS-1:0]   sine_in,
  input  logic                         ref_valid,
  output logic signed [OUT_BITS-1:0]   i_out,
  output logic signed [OUT_BITS-1:0]   q_out,
  output logic                         out_valid,
  output logic                         busy
);

  localparam int PROD_W    = AUDIO_BITS + LUT_BITS;
  localparam int ACC_W     = PROD_W + N_LOG2;
  localparam int FRAME_LEN = 2 ** N_LOG2;
  localparam int CNT_MAX   = (SETTLE_SAMPLES > FRAME_LEN) ? SETTLE_SAMPLES : FRAME_LEN;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, SETTLE, INTEG, DUMP} state_e;

  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic signed [PROD_W-1:0]   prod_i_q, prod_q_q;
  logic                       prod_valid_q;
  logic signed [ACC_W-1:0]    acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0]    acc_i_d, acc_q_d;
  logic signed [OUT_BITS-1:0] i_out_q, q_out_q;
  logic                       out_valid_q;

  logic signed [PROD_W-1:0]   audio_ext, cos_ext, sin_ext;

  assign audio_ext = PROD_W'(audio_in);
  assign cos_ext   = PROD_W'(cosine_in);
  assign sin_ext   = PROD_W'(sine_in);

  assign cnt_d   = cnt_q + 1'b1;
  assign acc_i_d = acc_i_q + ACC_W'(prod_i_q);
  assign acc_q_d = acc_q_q + ACC_W'(prod_q_q);

  // Products are formed on every reference strobe; the FSM decides whether to use them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_i_q     <= '0;
      prod_q_q     <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      prod_valid_q <= ref_valid;
      if (ref_valid) begin
        prod_i_q <= audio_ext * cos_ext;
        prod_q_q <= audio_ext * sin_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            if (start) state_q <= (SETTLE_SAMPLES == 0) ? INTEG : SETTLE;
          end
          SETTLE: begin
            if (prod_valid_q) begin
              if (cnt_d == SETTLE_CNT) begin
                cnt_q   <= '0;
                state_q <= INTEG;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          INTEG: begin
            if (prod_valid_q) begin
              acc_i_q <= acc_i_d;
              acc_q_q <= acc_q_d;
              cnt_q   <= cnt_d;
              if (cnt_d == FRAME_CNT) state_q <= DUMP;
            end
          end
          DUMP: begin
            // Top OUT_BITS of the sum: average by 2^N_LOG2, then floor-truncate.
            i_out_q     <= acc_i_q[ACC_W-1 -: OUT_BITS];
            q_out_q     <= acc_q_q[ACC_W-1 -: OUT_BITS];
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
`ifdef LOCKIN_CONTINUOUS_EN
            state_q     <= INTEG;
`else
            state_q     <= IDLE;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lockin_demod_integrator.sv
// tb/tb_lockin_demod_integrator.sv - directed self-checking bench for lockin_demod_integrator.
module tb_lockin_demod_integrator;

  localparam int AB = 24;
  localparam int LB = 18;
  localparam int OB = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 ref_valid = 1'b0;
  logic signed [AB-1:0] audio_in = '0;
  logic signed [LB-1:0] cosine_in = '0;
  logic signed [LB-1:0] sine_in = '0;
  logic signed [OB-1:0] i_out, q_out;
  logic                 out_valid, busy;

  lockin_demod_integrator #(
    .AUDIO_BITS(AB), .LUT_BITS(LB), .N_LOG2(4), .SETTLE_SAMPLES(2), .OUT_BITS(OB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .audio_in(audio_in), .cosine_in(cosine_in), .sine_in(sine_in), .ref_valid(ref_valid),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int ov_cnt = 0;
  int ov_cyc = 0;
  int ov_hist_cyc[8];
  longint ov_hist_i[8];
  logic signed [OB-1:0] ov_i = '0, ov_q = '0;
  logic ov_prev = 1'b0, busy_prev = 1'b0;
  logic ov_busy_before = 1'b0, busy_after_ov = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov_prev) busy_after_ov = busy;
    if (out_valid) begin
      if (ov_cnt < 8) begin
        ov_hist_cyc[ov_cnt] = cyc;
        ov_hist_i[ov_cnt]   = longint'(i_out);
      end
      ov_cnt++;
      ov_cyc = cyc;
      ov_i = i_out;
      ov_q = q_out;
      ov_busy_before = busy_prev;
    end
    ov_prev = out_valid;
    busy_prev = busy;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ref_pulse();
    ref_valid = 1'b1;
    ref_cyc = cyc;
    tick();
    ref_valid = 1'b0;
    repeat (7) tick();
  endtask

  task automatic set_refs(input int a, input int c, input int s);
    audio_in  = AB'(a);
    cosine_in = LB'(c);
    sine_in   = LB'(s);
  endtask

  int ov0;

  initial begin
    repeat (3) tick();
    check("rst_i_out", longint'(i_out), 0);
    check("rst_q_out", longint'(q_out), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    reset = 1'b1;
    repeat (2) tick();

`ifdef LOCKIN_CONTINUOUS_EN
    set_refs(1000, 131071, 0);
    ov0 = ov_cnt;
    pulse_start();
    repeat (50) ref_pulse();
    check("cont_pulses", longint'(ov_cnt - ov0), 3);
    for (int k = 0; k < 3; k++) check("cont_i_out", ov_hist_i[ov0 + k], 127999);
    check("cont_gap1", longint'(ov_hist_cyc[ov0 + 1] - ov_hist_cyc[ov0]), 128);
    check("cont_gap2", longint'(ov_hist_cyc[ov0 + 2] - ov_hist_cyc[ov0 + 1]), 128);
    check("cont_busy", longint'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cont_abort_busy", longint'(busy), 0);
`else
    // DC on the I channel, plus latency and busy framing
    set_refs(1000, 131071, 0);
    ov0 = ov_cnt;
    pulse_start();
    check("busy_after_start", longint'(busy), 1);
    repeat (18) ref_pulse();
    check("dc_pulses", longint'(ov_cnt - ov0), 1);
    check("dc_i_out", longint'(ov_i), 127999);
    check("dc_q_out", longint'(ov_q), 0);
    check("latency", longint'(ov_cyc - ref_cyc), 3);
    check("busy_before_ov", longint'(ov_busy_before), 1);
    check("busy_after_ov", longint'(busy_after_ov), 0);

    // Negative input on Q: floor truncation toward -inf
    set_refs(-1000, 0, 131071);
    ov0 = ov_cnt;
    pulse_start();
    repeat (18) ref_pulse();
    check("neg_pulses", longint'(ov_cnt - ov0), 1);
    check("neg_q_out", longint'(ov_q), -128000);
    check("neg_i_out", longint'(ov_i), 0);

    // start during INTEG is ignored
    set_refs(1000, 131071, 0);
    ov0 = ov_cnt;
    pulse_start();
    repeat (8) ref_pulse();
    pulse_start();
    repeat (10) ref_pulse();
    check("ign_pulses", longint'(ov_cnt - ov0), 1);
    check("ign_i_out", longint'(ov_i), 127999);

    // abort after 10 products: outputs hold
    set_refs(500, 100000, 20000);
    ov0 = ov_cnt;
    pulse_start();
    repeat (10) ref_pulse();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", longint'(busy), 0);
    repeat (8) ref_pulse();
    check("abort_no_ov", longint'(ov_cnt - ov0), 0);
    check("abort_i_hold", longint'(i_out), 127999);
    check("abort_q_hold", longint'(q_out), 0);

    // abort and start together while idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", longint'(busy), 0);
    repeat (18) ref_pulse();
    check("abort_start_no_ov", longint'(ov_cnt - ov0), 0);

    // abort coincident with DUMP
    set_refs(700, 131071, 5000);
    ov0 = ov_cnt;
    pulse_start();
    repeat (17) ref_pulse();
    ref_valid = 1'b1;
    tick();
    ref_valid = 1'b0;
    tick();
    check("dump_busy", longint'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (6) tick();
    check("dump_abort_no_ov", longint'(ov_cnt - ov0), 0);
    check("dump_abort_busy", longint'(busy), 0);
    check("dump_abort_i_hold", longint'(i_out), 127999);

    // asynchronous reset mid-INTEG, then a clean frame
    set_refs(1000, 131071, 0);
    pulse_start();
    repeat (6) ref_pulse();
    #2;
    reset = 1'b0;
    #1;
    check("arst_i_out", longint'(i_out), 0);
    check("arst_q_out", longint'(q_out), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_out_valid", longint'(out_valid), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    ov0 = ov_cnt;
    pulse_start();
    repeat (18) ref_pulse();
    check("post_rst_pulses", longint'(ov_cnt - ov0), 1);
    check("post_rst_i_out", longint'(ov_i), 127999);
    check("post_rst_q_out", longint'(ov_q), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
